// File: rtl/pwm_pkg.sv
// Shared definitions for the LED fade sequencer: default widths and FSM encoding.
package pwm_pkg;
  localparam int PWM_DUTY_W = 16;
  localparam int PWM_PERIOD = 50000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRIME      = 2'd1,
    PRIME_WAIT = 2'd2,
    RUN        = 2'd3
  } state_e;
endpackage

// File: rtl/pwm_fade_sequencer_btn_debounce.sv
// Two-flop synchroniser plus debounce counter; emits one pulse per clean press.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o
);
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  // Synchronised level is stored as "pressed" so the cleared state means released.
  logic             sync0_q, sync1_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= ~btn_n_i;
      sync1_q <= sync0_q;
      cnt_q   <= cnt_d;
    end
  end

  // Counter saturates at DEB_CYCLES so a held button fires only once.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync1_q) cnt_d = '0;
    else if (cnt_q != CNT_W'(DEB_CYCLES)) cnt_d = cnt_q + 1'b1;
  end

  assign press_o = sync1_q && (cnt_q == CNT_W'(DEB_CYCLES - 1));
endmodule

// File: rtl/pwm_fade_sequencer.sv
// Steps a duty ROM, holding each entry for HOLD_PERIODS PWM periods; duty changes only on period boundaries.
module pwm_fade_sequencer
  import pwm_pkg::*;
#(
  parameter int PERIOD       = PWM_PERIOD,
  parameter int DUTY_W       = PWM_DUTY_W,
  parameter int ADDR_W       = 4,
  parameter int ROM_LAST     = 15,
  parameter int HOLD_PERIODS = 10,
  parameter int DEB_CYCLES   = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_start_n,
  input  logic              btn_stop_n,
  input  logic              mode,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DUTY_W-1:0] rom_data,
  output logic [DUTY_W-1:0] duty,
  output logic              pwm_en,
  output logic              period_tick,
  output logic              busy
);
  localparam int PER_W  = $clog2(PERIOD);
  localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROM_LAST);

  function automatic logic [DUTY_W-1:0] clamp(input logic [DUTY_W-1:0] v);
    if (v > DUTY_W'(PERIOD)) return DUTY_W'(PERIOD);
    return v;
  endfunction

  // Returns {down, addr}; endpoints are visited once in ping-pong.
  function automatic logic [ADDR_W:0] next_addr(input logic [ADDR_W-1:0] a,
                                                input logic down, input logic pp);
    logic [ADDR_W:0] r;
    r = {1'b0, a + 1'b1};
    if (!pp) begin
      if (a == LAST) r = '0;
    end else if (down) begin
      if (a == '0) r = {1'b0, ADDR_W'(1)};
      else r = {1'b1, a - 1'b1};
    end else if (a == LAST) begin
      r = {1'b1, a - 1'b1};
    end
    return r;
  endfunction

  logic start_evt, stop_evt;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk(clk), .rst_n(rst_n), .btn_n_i(btn_start_n), .press_o(start_evt)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
    .clk(clk), .rst_n(rst_n), .btn_n_i(btn_stop_n), .press_o(stop_evt)
  );

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                down_q, down_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic [DUTY_W-1:0]   shadow_q, shadow_d;
  logic                en_q, en_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                rd_vld_p0_q, rd_vld_p0_d, rd_vld_p1_q, rd_vld_p1_d;
  logic                tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      down_q      <= 1'b0;
      duty_q      <= '0;
      shadow_q    <= '0;
      en_q        <= 1'b0;
      per_q       <= '0;
      hold_q      <= '0;
      rd_vld_p0_q <= 1'b0;
      rd_vld_p1_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      down_q      <= down_d;
      duty_q      <= duty_d;
      shadow_q    <= shadow_d;
      en_q        <= en_d;
      per_q       <= per_d;
      hold_q      <= hold_d;
      rd_vld_p0_q <= rd_vld_p0_d;
      rd_vld_p1_q <= rd_vld_p1_d;
    end
  end

  assign tick = en_q && (per_q == PER_W'(PERIOD - 1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    down_d      = down_q;
    duty_d      = duty_q;
    shadow_d    = shadow_q;
    en_d        = en_q;
    per_d       = per_q;
    hold_d      = hold_q;
    rd_vld_p0_d = 1'b0;
    rd_vld_p1_d = rd_vld_p0_q;

    if (en_q) per_d = tick ? '0 : per_q + 1'b1;
    // p0: new address on the ROM port; p1: its data is on rom_data
    if (rd_vld_p1_q) shadow_d = clamp(rom_data);

    case (state_q)
      IDLE: begin
        if (start_evt && !stop_evt) begin
          state_d = PRIME;
          addr_d  = '0;
          down_d  = 1'b0;
        end
      end
      PRIME: state_d = PRIME_WAIT;
      PRIME_WAIT: begin
        duty_d           = clamp(rom_data);
        en_d             = 1'b1;
        per_d            = '0;
        hold_d           = '0;
        {down_d, addr_d} = next_addr(addr_q, down_q, mode);
        rd_vld_p0_d      = 1'b1;
        state_d          = RUN;
      end
      RUN: begin
        if (tick) begin
          if (hold_q == HOLD_W'(HOLD_PERIODS - 1)) begin
            duty_d           = shadow_q;
            hold_d           = '0;
            {down_d, addr_d} = next_addr(addr_q, down_q, mode);
            rd_vld_p0_d      = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop_evt && (state_q != IDLE)) begin
      state_d     = IDLE;
      addr_d      = '0;
      down_d      = 1'b0;
      duty_d      = '0;
      shadow_d    = '0;
      en_d        = 1'b0;
      per_d       = '0;
      hold_d      = '0;
      rd_vld_p0_d = 1'b0;
      rd_vld_p1_d = 1'b0;
    end
  end

  assign rom_addr    = addr_q;
  assign duty        = duty_q;
  assign pwm_en      = en_q;
  assign period_tick = tick;
  assign busy        = (state_q != IDLE);
endmodule
